// File: rtl/sigdel_pkg.sv
// Shared types and constants for the sigma-delta read-out path.
// Holds the UART frame FSM state enum and frame geometry.
package sigdel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int UART_BYTES_PER_FRAME = 3;
  localparam int UART_DATA_BITS = 8;
  localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

  function automatic logic even_parity(
    input logic [7:0] b
  );
    return ^b;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter for the UART shifter.
// Ports: clk, rst_n, load (reload CLK_DIV-1), tick (count at 0).
module uart_bit_timer #(
  parameter int CLK_DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);

  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/sinc_uart_tx.sv
// Sends each captured 16-bit filter sample as UART frame A5,MSB,LSB.
// Ports: clk, rst_n, sample, sample_en, clr_ovf -> tx, busy, overflow.
// SINC_UART_PARITY_EN adds an even parity bit per byte (8E1).
module sinc_uart_tx
  import sigdel_pkg::*;
#(
  parameter int         CLK_DIV   = 434,
  parameter logic [7:0] SYNC_BYTE = UART_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sample,
  input  logic        sample_en,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  input  logic        clr_ovf
);

  uart_state_t state;
  uart_state_t state_d;

  logic [15:0] hold;
  logic        hold_full;
  logic [15:0] frame_buf;
  logic [15:0] frame_buf_d;
  logic [7:0]  shreg;
  logic [7:0]  shreg_d;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_d;
  logic [1:0]  byte_idx;
  logic [1:0]  byte_idx_d;
  logic        tx_q;
  logic        tx_d;
  logic        ovf_q;
  logic        load;
  logic        tick;
  logic        consume;
  logic        drop;

`ifdef SINC_UART_PARITY_EN
  logic par;
  logic par_d;
`endif

  uart_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .tick (tick)
  );

  // hold is released the cycle IDLE copies it, so a
  // strobe in that same cycle is accepted, not dropped
  assign consume = (state == ST_IDLE) && hold_full;
  assign drop    = sample_en && hold_full && !consume;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (sample_en && !drop) begin
      hold      <= sample;
      hold_full <= 1'b1;
    end else if (consume) begin
      hold_full <= 1'b0;
    end
  end

  // a drop in the same cycle as clr_ovf keeps the flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      frame_buf <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      tx_q      <= 1'b1;
    end else begin
      state     <= state_d;
      frame_buf <= frame_buf_d;
      shreg     <= shreg_d;
      bit_idx   <= bit_idx_d;
      byte_idx  <= byte_idx_d;
      tx_q      <= tx_d;
    end
  end

`ifdef SINC_UART_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= 1'b0;
    end else begin
      par <= par_d;
    end
  end
`endif

  always_comb begin
    state_d     = state;
    frame_buf_d = frame_buf;
    shreg_d     = shreg;
    bit_idx_d   = bit_idx;
    byte_idx_d  = byte_idx;
    load        = 1'b0;
`ifdef SINC_UART_PARITY_EN
    par_d       = par;
`endif
    unique case (state)
      ST_IDLE: begin
        if (hold_full) begin
          frame_buf_d = hold;
          byte_idx_d  = '0;
          shreg_d     = SYNC_BYTE;
          load        = 1'b1;
          state_d     = ST_START;
`ifdef SINC_UART_PARITY_EN
          par_d       = even_parity(SYNC_BYTE);
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          bit_idx_d = '0;
          load      = 1'b1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          load    = 1'b1;
          shreg_d = {1'b0, shreg[7:1]};
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef SINC_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          load    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          load = 1'b1;
          if (byte_idx < 2'(UART_BYTES_PER_FRAME - 1)) begin
            byte_idx_d = byte_idx + 2'd1;
            shreg_d    = (byte_idx == 2'd0) ?
                         frame_buf[15:8] : frame_buf[7:0];
            state_d    = ST_START;
`ifdef SINC_UART_PARITY_EN
            par_d      = even_parity(shreg_d);
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // tx is registered from the next state so the pin never
  // glitches while the state and shifter switch together
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
`ifdef SINC_UART_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign busy     = (state != ST_IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sinc_uart_tx.sv
// Randomized self-checking bench for sinc_uart_tx (CLK_DIV=4).
// Frame-position reference model plus literal decoded-byte checks.
`timescale 1ns/1ps
module tb_sinc_uart_tx;

  localparam int DIV = 4;
`ifdef SINC_UART_PARITY_EN
  localparam int BPB = 11;
  localparam int EXP_LEN = 132;
`else
  localparam int BPB = 10;
  localparam int EXP_LEN = 120;
`endif
  localparam int NBITS = 3 * BPB;
  localparam int FLEN = NBITS * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sample = '0;
  logic        sample_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        tx;
  logic        busy;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  sinc_uart_tx #(
    .CLK_DIV(DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample   (sample),
    .sample_en(sample_en),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #10 clk = ~clk;

  task automatic check(input string nm,
                       input logic [23:0] act,
                       input logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Frame as a flat bit string in line order, bit 0 first.
  function automatic logic [NBITS-1:0] mk_frame(
    input logic [15:0] v
  );
    logic [NBITS-1:0] f;
    logic [7:0] b;
    f = '0;
    for (int j = 0; j < 3; j++) begin
      b = (j == 0) ? 8'hA5 : (j == 1) ? v[15:8] : v[7:0];
      f[j*BPB] = 1'b0;
      for (int i = 0; i < 8; i++) f[j*BPB+1+i] = b[i];
`ifdef SINC_UART_PARITY_EN
      f[j*BPB+9] = ^b;
`endif
      f[j*BPB+BPB-1] = 1'b1;
    end
    return f;
  endfunction

  logic             m_full = 1'b0;
  logic             m_ovf = 1'b0;
  logic             m_active = 1'b0;
  logic [15:0]      m_hold = '0;
  int               m_pos = 0;
  logic [NBITS-1:0] m_frame = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full   = 1'b0;
      m_ovf    = 1'b0;
      m_active = 1'b0;
      m_pos    = 0;
    end else begin : mdl
      logic take;
      logic was_full;
      logic drop;
      take     = !m_active && m_full;
      was_full = m_full;
      drop     = sample_en && was_full && !take;
      if (m_active) begin
        m_pos++;
        if (m_pos == FLEN) m_active = 1'b0;
      end
      if (take) begin
        m_frame  = mk_frame(m_hold);
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (sample_en && !drop) begin
        m_hold = sample;
        m_full = 1'b1;
      end else if (take) begin
        m_full = 1'b0;
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  always @(posedge clk) begin : cmp
    logic exp_tx;
    #1;
    if (rst_n) begin
      exp_tx = m_active ? m_frame[m_pos/DIV] : 1'b1;
      check("model_tx", 24'(tx), 24'(exp_tx));
      check("model_busy", 24'(busy), 24'(m_active));
      check("model_ovf", 24'(overflow), 24'(m_ovf));
    end
  end

  int          inj_c[$];
  logic [15:0] inj_v[$];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] v);
    sample    = v;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    sample    = 16'($urandom);
  endtask

  // Starts on the first start-bit cycle; records one frame.
  task automatic capture(output logic [23:0] bytes,
                         output logic [2:0]  pb,
                         output int          bcnt,
                         output int          wbad);
    logic samp [FLEN];
    bcnt = 0;
    wbad = 0;
    bytes = '0;
    pb = '0;
    for (int c = 0; c < FLEN; c++) begin
      samp[c] = tx;
      if (busy) bcnt++;
      if (inj_c.size() > 0 && inj_c[0] == c) begin
        sample    = inj_v.pop_front();
        sample_en = 1'b1;
        void'(inj_c.pop_front());
      end else begin
        sample_en = 1'b0;
      end
      @(negedge clk);
    end
    sample_en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 8; i++)
        bytes[(2-j)*8+i] = samp[(j*BPB+1+i)*DIV+1];
      pb[j] = samp[(j*BPB+9)*DIV+1];
    end
    for (int k = 0; k < NBITS; k++)
      for (int d = 1; d < DIV; d++)
        if (samp[k*DIV+d] !== samp[k*DIV]) wbad++;
  endtask

  logic [23:0] by;
  logic [2:0]  pb;
  int          bc;
  int          wb;
  logic [15:0] v0;
  int          bad;

  initial begin
    cyc(3);
    check("reset_tx", 24'(tx), 24'h1);
    check("reset_busy", 24'(busy), 24'h0);
    check("reset_ovf", 24'(overflow), 24'h0);
    rst_n = 1'b1;
    cyc(2);

    pulse(16'h1234);
    check("tx_before_start", 24'(tx), 24'h1);
    cyc(1);
    check("tx_fall", 24'(tx), 24'h0);
    capture(by, pb, bc, wb);
    check("frame1_bytes", by, 24'hA51234);
    check("frame1_busy_len", 24'(bc), 24'(EXP_LEN));
    check("frame1_bit_width", 24'(wb), 24'h0);
    check("frame1_end_tx", 24'(tx), 24'h1);
    check("frame1_end_busy", 24'(busy), 24'h0);

    cyc(3);
    v0 = 16'($urandom);
    pulse(v0);
    cyc(1);
    inj_c.push_back(50);
    inj_v.push_back(16'hBEEF);
    capture(by, pb, bc, wb);
    check("buf_frame_a", by, {8'hA5, v0});
    check("buf_idle_gap", 24'(busy), 24'h0);
    check("buf_no_ovf", 24'(overflow), 24'h0);
    cyc(1);
    check("buf_frame2_start", 24'({busy, tx}), 24'h2);
    capture(by, pb, bc, wb);
    check("buf_frame_b", by, 24'hA5BEEF);

    cyc(2);
    pulse(16'h1111);
    cyc(1);
    inj_c.push_back(10);
    inj_v.push_back(16'h2222);
    inj_c.push_back(30);
    inj_v.push_back(16'h3333);
    inj_c.push_back(70);
    inj_v.push_back(16'h4444);
    capture(by, pb, bc, wb);
    check("ovf_frame_a", by, 24'hA51111);
    check("ovf_set", 24'(overflow), 24'h1);
    cyc(1);
    capture(by, pb, bc, wb);
    check("ovf_second_sent", by, 24'hA52222);
    check("ovf_sticky", 24'(overflow), 24'h1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", 24'(overflow), 24'h0);

    pulse(16'h6666);
    cyc(3);
    pulse(16'h7777);
    sample    = 16'h8888;
    sample_en = 1'b1;
    clr_ovf   = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    clr_ovf   = 1'b0;
    check("clr_vs_event", 24'(overflow), 24'h1);
    cyc(2 * FLEN + 10);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;

`ifdef SINC_UART_PARITY_EN
    pulse(16'h0103);
    cyc(1);
    capture(by, pb, bc, wb);
    check("par_bytes", by, 24'hA50103);
    check("par_bits", 24'(pb), 24'h2);
    check("par_len", 24'(bc), 24'(EXP_LEN));
`endif

    cyc(5);
    pulse(16'($urandom));
    cyc(1);
    cyc(BPB * DIV + 3 * DIV + 1);
    check("pre_reset_busy", 24'(busy), 24'h1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_tx", 24'(tx), 24'h1);
    check("async_rst_busy", 24'(busy), 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("no_residual_frame", 24'(bad), 24'h0);

    for (int i = 0; i < 8000; i++) begin
      sample    = 16'($urandom);
      sample_en = ($urandom_range(0, 99) < 3);
      clr_ovf   = ($urandom_range(0, 99) < 2);
      @(negedge clk);
    end
    sample_en = 1'b0;
    clr_ovf   = 1'b0;
    cyc(2 * FLEN + 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
